// File: rtl/noc_flit_fifo.sv
// First-word-fall-through flit buffer for a NoC router input port.
// Tracks resident tail flits so downstream logic can see when a whole packet is buffered.
module noc_flit_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_flit,
   input  logic             in_tail,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_flit,
   output logic             out_tail,
   output logic [AW:0]      count,
   output logic             pkt_avail,
   output logic             ovf_err
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] tail_mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      tail_cnt;
   logic             push;
   logic             pop;
   logic             push_tail;
   logic             pop_tail;

   // Ready depends on stored state only, so a full buffer refuses a push even while popping.
   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign push_tail = push & in_tail;
   assign pop_tail  = pop & out_tail;
   assign pkt_avail = (tail_cnt != '0);

   // Empty outputs are forced to zero so they stay stable and read as reset values.
   assign out_flit = out_valid ? mem[rd_ptr] : '0;
   assign out_tail = out_valid ? tail_mem[rd_ptr] : 1'b0;

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr]      <= in_flit;
         tail_mem[wr_ptr] <= in_tail;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         tail_cnt <= '0;
         ovf_err  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         case ({push_tail, pop_tail})
            2'b10:   tail_cnt <= tail_cnt + (AW+1)'(1);
            2'b01:   tail_cnt <= tail_cnt - (AW+1)'(1);
            default: tail_cnt <= tail_cnt;
         endcase
         if (in_valid && !in_ready) ovf_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_noc_flit_fifo.sv
// Directed self-checking bench for noc_flit_fifo: reset, latency, fill/drain order,
// full backpressure, pointer wrap and mid-packet reset.
module tb_noc_flit_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_flit;
   logic        in_tail;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_flit;
   logic        out_tail;
   logic [3:0]  count;
   logic        pkt_avail;
   logic        ovf_err;

   int checks = 0;
   int errors = 0;

   noc_flit_fifo #(.WIDTH(32), .DEPTH(8), .AW(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit), .in_tail(in_tail),
      .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit), .out_tail(out_tail),
      .count(count), .pkt_avail(pkt_avail), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_flit;

      // Reset held two cycles with in_valid asserted
      rst = 1'b1; in_valid = 1'b1; in_flit = 32'hDEAD_BEEF; in_tail = 1'b1; out_ready = 1'b0;
      step();
      step();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_pkt_avail", pkt_avail, 0);
      check("rst_ovf_err", ovf_err, 0);
      check("rst_out_flit", out_flit, 0);
      check("rst_out_tail", out_tail, 0);

      // Latency: push at cycle N, visible at N+1
      in_valid = 1'b1; in_flit = 32'hA5A5_0001; in_tail = 1'b1;
      #1;
      check("lat_no_bypass", out_valid, 0);
      step();
      in_valid = 1'b0;
      check("lat_out_valid", out_valid, 1);
      check("lat_out_flit", out_flit, 32'hA5A5_0001);
      check("lat_out_tail", out_tail, 1);
      check("lat_pkt_avail", pkt_avail, 1);
      check("lat_count", count, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("lat_pop_count", count, 0);
      check("lat_pop_pkt", pkt_avail, 0);

      // Fill with 0..7, tails on 3 and 7
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_flit = 32'(i); in_tail = (i == 3) || (i == 7);
         step();
      end
      in_valid = 1'b0; in_tail = 1'b0;
      check("fill_in_ready", in_ready, 0);
      check("fill_count", count, 8);
      check("fill_pkt_avail", pkt_avail, 1);
      check("fill_ovf_err", ovf_err, 0);

      // Drain in order; first pop coincides with a refused push while full
      for (int i = 0; i < 8; i++) begin
         check("drain_valid", out_valid, 1);
         check("drain_flit", out_flit, 64'(i));
         check("drain_tail", out_tail, ((i == 3) || (i == 7)) ? 1 : 0);
         out_ready = 1'b1;
         if (i == 0) begin
            in_valid = 1'b1; in_flit = 32'h0000_0099; in_tail = 1'b1;
         end
         step();
         if (i == 0) begin
            in_valid = 1'b0; in_tail = 1'b0;
            check("bp_count", count, 7);
            check("bp_ovf_err", ovf_err, 1);
            check("bp_in_ready", in_ready, 1);
            check("bp_pkt_avail", pkt_avail, 1);
         end
         if (i == 3) check("drain_pkt_after3", pkt_avail, 1);
      end
      out_ready = 1'b0;
      check("drain_count", count, 0);
      check("drain_out_valid", out_valid, 0);
      check("drain_pkt_avail", pkt_avail, 0);
      check("drain_ovf_sticky", ovf_err, 1);

      // Wrap-around: prefill 3, then 40 cycles of simultaneous push/pop
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_flit = 32'(100 + i); in_tail = 1'b0;
         step();
      end
      check("wrap_prefill", count, 3);
      exp_flit = 32'd100;
      for (int k = 0; k < 40; k++) begin
         check("wrap_flit", out_flit, exp_flit);
         in_valid = 1'b1; in_flit = 32'(103 + k); out_ready = 1'b1;
         step();
         check("wrap_count", count, 3);
         exp_flit = exp_flit + 32'd1;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("wrap_final_flit", out_flit, 32'd140);
      check("wrap_pkt_avail", pkt_avail, 0);

      // Mid-packet reset: head+body without tail, then rst
      in_valid = 1'b1; in_flit = 32'h0000_0011; in_tail = 1'b0;
      step();
      in_flit = 32'h0000_0022;
      step();
      check("mid_pre_count", count, 5);
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_count", count, 0);
      check("mid_pkt_avail", pkt_avail, 0);
      check("mid_out_valid", out_valid, 0);
      check("mid_ovf_clear", ovf_err, 0);
      in_valid = 1'b1; in_flit = 32'h0000_0077; in_tail = 1'b1;
      step();
      in_valid = 1'b0; in_tail = 1'b0;
      check("mid_tail_pkt", pkt_avail, 1);
      check("mid_tail_flit", out_flit, 32'h0000_0077);
      check("mid_tail_count", count, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
